// File: rtl/async_fifo_flags.sv
// ---------------------------------------------------------------------------
// async_fifo_flags
//
// Dual-clock FIFO carrying DSIZE-bit words from the wclk domain to the rclk
// domain. Full/empty use Gray pointers passed through SYNC_STAGES-deep
// synchronisers. The FIFO also provides fill levels in both domains,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// flags, and an optional first-word-fall-through (FWFT) read mode.
//
// Parameters
//   DSIZE        data word width
//   ASIZE        address bits; memory depth is 2**ASIZE (ASIZE >= 2)
//   SYNC_STAGES  flops per pointer / reset synchroniser (2..4)
//   AF_LEVEL     walmost_full when write-side level >= AF_LEVEL
//   AE_LEVEL     ralmost_empty when read-side level <= AE_LEVEL
//   FWFT         0: rdata valid one rclk after the pop
//                1: head word shown on rdata whenever !rempty
//
// Ports
//   rclk, wclk     read / write clocks
//   wrst           asynchronous active-low reset for both domains
//   winc, wdata    write request and data
//   wfull          memory full; writes are dropped
//   walmost_full   write level >= AF_LEVEL
//   wlevel         write-side occupancy 0..2**ASIZE (may overstate)
//   woverflow      sticky: write attempted while full
//   rinc           read / pop request
//   rdata          read data
//   rempty         no word available
//   ralmost_empty  read level <= AE_LEVEL
//   rlevel         read-side occupancy (may understate)
//   runderflow     sticky: read attempted while empty
// ---------------------------------------------------------------------------
module async_fifo_flags #(
  parameter int DSIZE       = 8,
  parameter int ASIZE       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = (1 << ASIZE) - 4,
  parameter int AE_LEVEL    = 4,
  parameter bit FWFT        = 1'b0
) (
  input  logic             rclk,
  input  logic             wclk,
  input  logic             wrst,
  // write domain
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow,
  // read domain
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);

  localparam int PW    = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;

  localparam logic [ASIZE:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_THR = PW'(AE_LEVEL);

  // -------------------------------------------------------------------------
  // Pointer encoding helpers
  // -------------------------------------------------------------------------
  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // -------------------------------------------------------------------------
  // Reset synchronisers: assertion is immediate in both domains, release is
  // retimed into each domain separately.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] wrst_sync_q;
  logic [SYNC_STAGES-1:0] rrst_sync_q;
  logic                   wrst_n;
  logic                   rrst_n;

  // NOTE: the raw reset drives only the synchroniser; all other flops use the
  // local released copy so no flop leaves reset on an unsafe edge.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) wrst_sync_q <= '0;
    else       wrst_sync_q <= {wrst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) rrst_sync_q <= '0;
    else       rrst_sync_q <= {rrst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign wrst_n = wrst_sync_q[SYNC_STAGES-1];
  assign rrst_n = rrst_sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DSIZE-1:0] mem [DEPTH];

  // -------------------------------------------------------------------------
  // Write domain state
  // -------------------------------------------------------------------------
  logic [ASIZE:0] wbin_q,  wbin_d;
  logic [ASIZE:0] wgray_q, wgray_d;
  logic           wfull_q, wfull_d;
  logic           walmost_full_q, walmost_full_d;
  logic [ASIZE:0] wlevel_q, wlevel_d;
  logic           woverflow_q, woverflow_d;
  logic           wpush;

  // Read pointer as seen from the write side
  logic [SYNC_STAGES-1:0][ASIZE:0] rgray_sync_q;
  logic [ASIZE:0]                  rgray_ws;
  logic [ASIZE:0]                  rbin_ws;

  // -------------------------------------------------------------------------
  // Read domain state
  // -------------------------------------------------------------------------
  logic [ASIZE:0]   rbin_q,  rbin_d;
  logic [ASIZE:0]   rgray_q, rgray_d;
  logic             mem_empty_q, mem_empty_d;   // memory holds no unread word
  logic             ov_q, ov_d;                 // FWFT output register valid
  logic             ralmost_empty_q, ralmost_empty_d;
  logic [ASIZE:0]   rlevel_q, rlevel_d;
  logic             runderflow_q, runderflow_d;
  logic [DSIZE-1:0] rdata_q;
  logic             mem_pop;
  logic             rempty_int;

  // Write pointer as seen from the read side
  logic [SYNC_STAGES-1:0][ASIZE:0] wgray_sync_q;
  logic [ASIZE:0]                  wgray_rs;
  logic [ASIZE:0]                  wbin_rs;

  // -------------------------------------------------------------------------
  // Pointer synchronisers (Gray only crosses domains)
  // -------------------------------------------------------------------------
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) rgray_sync_q <= '0;
    else         rgray_sync_q <= {rgray_sync_q[SYNC_STAGES-2:0], rgray_q};
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) wgray_sync_q <= '0;
    else         wgray_sync_q <= {wgray_sync_q[SYNC_STAGES-2:0], wgray_q};
  end

  assign rgray_ws = rgray_sync_q[SYNC_STAGES-1];
  assign wgray_rs = wgray_sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Write domain next state
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    wpush   = winc && !wfull_q;
    wbin_d  = wbin_q + {{ASIZE{1'b0}}, wpush};
    wgray_d = bin2gray(wbin_d);
    rbin_ws = gray2bin(rgray_ws);
    // Full when the writer is exactly one lap ahead: in Gray code that is the
    // reader pointer with its two MSBs inverted.
    wfull_d        = (wgray_d == {~rgray_ws[ASIZE:ASIZE-1], rgray_ws[ASIZE-2:0]});
    wlevel_d       = wbin_d - rbin_ws;
    walmost_full_d = (wlevel_d >= AF_THR);
    woverflow_d    = woverflow_q | (winc & wfull_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= wlevel_d;
      woverflow_q    <= woverflow_d;
    end
  end

  // NOTE: the storage array has no reset; contents are only ever read behind
  // a pointer that was reset, so stale words are unreachable.
  always_ff @(posedge wclk) begin
    if (wpush) mem[wbin_q[ASIZE-1:0]] <= wdata;
  end

  // -------------------------------------------------------------------------
  // Read domain next state
  // -------------------------------------------------------------------------
  // In standard mode the reader's empty flag is the memory-empty flag. In
  // FWFT mode the visible flag is the output register's valid bit, and the
  // memory is popped whenever that register is free or being consumed.
  assign rempty_int = FWFT ? !ov_q : mem_empty_q;

  always_comb begin
    mem_pop = 1'b0;
    ov_d    = ov_q;
    if (FWFT) begin
      mem_pop = !mem_empty_q && (!ov_q || rinc);
      if (mem_pop)   ov_d = 1'b1;
      else if (rinc) ov_d = 1'b0;
    end else begin
      mem_pop = rinc && !mem_empty_q;
    end
    rbin_d          = rbin_q + {{ASIZE{1'b0}}, mem_pop};
    rgray_d         = bin2gray(rbin_d);
    wbin_rs         = gray2bin(wgray_rs);
    mem_empty_d     = (rgray_d == wgray_rs);
    // The FWFT output register is deliberately not counted here.
    rlevel_d        = wbin_rs - rbin_d;
    ralmost_empty_d = (rlevel_d <= AE_THR);
    runderflow_d    = runderflow_q | (rinc & rempty_int);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q          <= '0;
      rgray_q         <= '0;
      mem_empty_q     <= 1'b1;
      ov_q            <= 1'b0;
      ralmost_empty_q <= 1'b1;
      rlevel_q        <= '0;
      runderflow_q    <= 1'b0;
    end else begin
      rbin_q          <= rbin_d;
      rgray_q         <= rgray_d;
      mem_empty_q     <= mem_empty_d;
      ov_q            <= ov_d;
      ralmost_empty_q <= ralmost_empty_d;
      rlevel_q        <= rlevel_d;
      runderflow_q    <= runderflow_d;
    end
  end

  // Read data register: loaded only by an accepted memory pop, so an
  // underflow or idle cycle leaves rdata untouched.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)      rdata_q <= '0;
    else if (mem_pop) rdata_q <= mem[rbin_q[ASIZE-1:0]];
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wfull         = wfull_q;
  assign walmost_full  = walmost_full_q;
  assign wlevel        = wlevel_q;
  assign woverflow     = woverflow_q;
  assign rdata         = rdata_q;
  assign rempty        = rempty_int;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = runderflow_q;

endmodule
